// File: rtl/seq_arb_pkg.sv
// ============================================================================
// seq_arb_pkg : shared encodings for the two-requester serial pattern detector
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } ctrl_state_e;

  // Detector states name the longest useful suffix seen; HIT states are the matches.
  typedef enum logic [2:0] {
    DET_S0      = 3'd0,
    DET_S1      = 3'd1,
    DET_S11     = 3'd2,
    DET_S110    = 3'd3,
    DET_S111    = 3'd4,
    DET_HIT1101 = 3'd5,
    DET_HIT1111 = 3'd6
  } det_state_e;

  localparam logic [3:0] PAT_ALL_ONES = 4'b1111;
  localparam logic [3:0] PAT_1101     = 4'b1101;

endpackage

`default_nettype wire

// File: rtl/seq_detector.sv
// ============================================================================
// seq_detector : Moore detector, z=1 the cycle after the last four bits were
// 1111 or 1101 (overlapping). Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detector
  import seq_arb_pkg::*;
(
  input  logic Clock,
  input  logic clr,
  input  logic w,
  output logic z
);

  det_state_e state_q, state_d;

  always_ff @(posedge Clock) begin
    if (clr) state_q <= DET_S0;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = DET_S0;
    case (state_q)
      DET_S0:      state_d = w ? DET_S1      : DET_S0;
      DET_S1:      state_d = w ? DET_S11     : DET_S0;
      DET_S11:     state_d = w ? DET_S111    : DET_S110;
      DET_S110:    state_d = w ? DET_HIT1101 : DET_S0;
      DET_S111:    state_d = w ? DET_HIT1111 : DET_S110;
      DET_HIT1101: state_d = w ? DET_S11     : DET_S0;
      DET_HIT1111: state_d = w ? DET_HIT1111 : DET_S110;
      default:     state_d = DET_S0;
    endcase
  end

  assign z = (state_q == DET_HIT1101) || (state_q == DET_HIT1111);

endmodule

`default_nettype wire

// File: rtl/seq_detect_arbiter.sv
// ============================================================================
// seq_detect_arbiter : arbitrates two word requesters onto one serial detector
// and reports per-word match counts. Option macro: SEQ_ARB_FIXED_PRIO_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detect_arbiter
  import seq_arb_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              req0_valid,
  input  logic [WORD_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [WORD_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              res_valid,
  output logic              res_id,
  output logic [CNT_W-1:0]  res_count,
  output logic              busy,
  output logic              det_w,
  output logic              det_z
);

  localparam int BIT_W = $clog2(WORD_W);

  ctrl_state_e       state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0]  hits_q, hits_d;
  logic              owner_q, owner_d;
  logic              res_id_q, res_id_d;
  logic [CNT_W-1:0]  res_count_q, res_count_d;

  logic any_valid;
  logic grant;
  logic accept;
  logic hit_inc;
  logic det_clr;

`ifdef SEQ_ARB_FIXED_PRIO_EN
  assign grant = ~req0_valid;
`else
  logic last_q, last_d;

  assign grant  = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  assign last_d = accept ? grant : last_q;

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge Clock) begin
    if (!Resetn) last_q <= 1'b1;
    else         last_q <= last_d;
  end
`endif

  assign any_valid  = req0_valid | req1_valid;
  assign accept     = Resetn && (state_q == ST_IDLE) && any_valid;
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  // SHIFT bit 0 sees z from the cleared detector, so only later bits can score.
  assign hit_inc = det_z && !(&hits_q) &&
                   (((state_q == ST_SHIFT) && (bitcnt_q != '0)) || (state_q == ST_DRAIN));

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    hits_d      = hits_q;
    owner_d     = owner_q;
    res_id_d    = res_id_q;
    res_count_d = res_count_q;
    if (hit_inc) hits_d = hits_q + CNT_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d  = grant ? req1_data : req0_data;
          owner_d  = grant;
          hits_d   = '0;
          bitcnt_d = '0;
          state_d  = ST_CLR;
        end
      end
      ST_CLR: state_d = ST_SHIFT;
      ST_SHIFT: begin
        shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
        if (bitcnt_q == BIT_W'(WORD_W - 1)) state_d = ST_DRAIN;
        else                                bitcnt_d = bitcnt_q + BIT_W'(1);
      end
      ST_DRAIN: begin
        res_count_d = hits_d;
        res_id_d    = owner_q;
        state_d     = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      hits_q      <= '0;
      owner_q     <= 1'b0;
      res_id_q    <= 1'b0;
      res_count_q <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      hits_q      <= hits_d;
      owner_q     <= owner_d;
      res_id_q    <= res_id_d;
      res_count_q <= res_count_d;
    end
  end

  assign det_clr = !Resetn || (state_q == ST_CLR);

  seq_detector u_det (
    .Clock (Clock),
    .clr   (det_clr),
    .w     (det_w),
    .z     (det_z)
  );

  assign det_w     = (state_q == ST_SHIFT) ? shreg_q[WORD_W-1] : 1'b0;
  assign busy      = (state_q != ST_IDLE);
  assign res_valid = (state_q == ST_DONE);
  assign res_id    = res_id_q;
  assign res_count = res_count_q;

endmodule

`default_nettype wire
